// File: rtl/kernel_scheduler.sv
// rtl/kernel_scheduler.sv - frame-synchronous 3x3 convolution kernel selector and loader
//
// Holds the six-entry kernel table, tracks the user's selection (next/prev
// pulses plus optional auto-cycle) and preloads the chosen kernel into a
// shadow bank one entry per cycle. The shadow bank is copied to the active
// outputs only on a frame-start pulse, so a frame never sees mixed kernels.
//
// Ports:
//   clk_in         system clock
//   rst_in         asynchronous active-high reset
//   next_in        pulse: select next kernel
//   prev_in        pulse: select previous kernel
//   frame_start_in pulse at the first pixel of each frame
//   coeffs_out     active coefficients [row][col], signed 8-bit
//   shift_out      active right-shift
//   offset_out     active signed offset
//   kernel_id_out  active kernel index, 7 = none loaded
//   pending_out    high while a change is queued or loading
//   swap_out       one-cycle pulse in the cycle the new kernel becomes active
module kernel_scheduler #(
  parameter int NUM_KERNELS    = 6,
  parameter int DEFAULT_KERNEL = 0,
  parameter int AUTO_FRAMES    = 0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     next_in,
  input  logic                     prev_in,
  input  logic                     frame_start_in,
  output logic signed [2:0][2:0][7:0] coeffs_out,
  output logic [7:0]               shift_out,
  output logic signed [7:0]        offset_out,
  output logic [2:0]               kernel_id_out,
  output logic                     pending_out,
  output logic                     swap_out
);

  localparam logic [2:0]  LAST_SEL  = 3'(NUM_KERNELS - 1);
  localparam logic [15:0] AUTO_LAST = 16'(AUTO_FRAMES - 1);
  localparam logic [3:0]  LAST_IDX  = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]  r_sel;
  logic [2:0]  w_sel_nxt;
  logic [15:0] r_frame_cnt;
  logic [2:0]  r_load_id;
  logic [3:0]  r_idx;
  logic [7:0]  r_shadow [0:10];
  logic signed [2:0][2:0][7:0] r_coeffs;
  logic [7:0]  r_shift;
  logic [7:0]  r_offset;
  logic [2:0]  r_kernel_id;
  logic        r_pending;
  logic        r_swap;

  logic w_press_next;
  logic w_press_prev;
  logic w_manual;
  logic w_auto;
  logic w_start_load;
  logic w_write;
  logic w_swap;

  // Table entries 0..8 are row-major coefficients, 9 = shift, 10 = offset.
  function automatic logic [7:0] table_entry(input logic [2:0] id, input logic [3:0] idx);
    logic [7:0] e [0:10];
    case (id)
      3'd1:    e = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h04, 8'h02, 8'h01, 8'h02, 8'h01, 8'h04, 8'h00};
      3'd2:    e = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h05, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h10};
      3'd3:    e = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h10};
      3'd4:    e = '{8'h01, 8'h00, 8'hFF, 8'h02, 8'h00, 8'hFE, 8'h01, 8'h00, 8'hFF, 8'h00, 8'h00};
      3'd5:    e = '{8'hFF, 8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h01, 8'h00, 8'h00};
      default: e = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    endcase
    return (idx <= LAST_IDX) ? e[idx] : 8'h00;
  endfunction

  // Simultaneous next and prev cancel out and count as no press at all.
  assign w_press_next = next_in & ~prev_in;
  assign w_press_prev = prev_in & ~next_in;
  assign w_manual     = w_press_next | w_press_prev;
  assign w_auto       = (AUTO_FRAMES != 0) && frame_start_in && (r_frame_cnt == AUTO_LAST);

  always_comb begin
    w_sel_nxt = r_sel;
    if (w_press_next || (w_auto && !w_manual)) begin
      w_sel_nxt = (r_sel == LAST_SEL) ? 3'd0 : r_sel + 3'd1;
    end else if (w_press_prev) begin
      w_sel_nxt = (r_sel == 3'd0) ? LAST_SEL : r_sel - 3'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start_load = 1'b0;
    w_write      = 1'b0;
    w_swap       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_sel != r_kernel_id) begin
          w_state_nxt  = S_LOAD;
          w_start_load = 1'b1;
        end
      end
      S_LOAD, S_READY: begin
        // A selection change while loading or waiting wins over everything:
        // either fall back to the kernel already active, or reload.
        if (r_sel != r_load_id) begin
          if (r_sel == r_kernel_id) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt  = S_LOAD;
            w_start_load = 1'b1;
          end
        end else if (r_state == S_LOAD) begin
          w_write = 1'b1;
          if (r_idx == LAST_IDX) w_state_nxt = S_READY;
        end else if (frame_start_in) begin
          w_state_nxt = S_IDLE;
          w_swap      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sel       <= 3'(DEFAULT_KERNEL);
      r_frame_cnt <= '0;
      r_load_id   <= '0;
      r_idx       <= '0;
      for (int i = 0; i < 11; i++) r_shadow[i] <= '0;
      r_coeffs    <= '0;
      r_shift     <= '0;
      r_offset    <= '0;
      r_kernel_id <= 3'd7;
      r_pending   <= 1'b0;
      r_swap      <= 1'b0;
    end else begin
      r_sel     <= w_sel_nxt;
      r_swap    <= w_swap;
      r_pending <= (r_state != S_IDLE) || (r_sel != r_kernel_id);
      if (w_manual || w_auto)  r_frame_cnt <= '0;
      else if (frame_start_in) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_start_load) begin
        r_load_id <= r_sel;
        r_idx     <= '0;
      end
      if (w_write) begin
        r_shadow[r_idx] <= table_entry(r_load_id, r_idx);
        r_idx           <= r_idx + 4'd1;
      end
      if (w_swap) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            r_coeffs[r][c] <= r_shadow[r*3 + c];
        r_shift     <= r_shadow[9];
        r_offset    <= r_shadow[10];
        r_kernel_id <= r_load_id;
      end
    end
  end

  assign coeffs_out    = r_coeffs;
  assign shift_out     = r_shift;
  assign offset_out    = r_offset;
  assign kernel_id_out = r_kernel_id;
  assign pending_out   = r_pending;
  assign swap_out      = r_swap;

endmodule

// File: tb/tb_kernel_scheduler.sv
// tb/tb_kernel_scheduler.sv - directed self-checking bench for kernel_scheduler
module tb_kernel_scheduler;

  logic clk = 1'b0;
  logic rst_in = 1'b1;
  logic next_in = 1'b0, prev_in = 1'b0, frame_in = 1'b0;
  logic a_next = 1'b0, a_prev = 1'b0, a_frame = 1'b0;

  logic signed [2:0][2:0][7:0] coeffs, a_coeffs;
  logic [7:0] shift, a_shift;
  logic signed [7:0] offset, a_offset;
  logic [2:0] kid, a_kid;
  logic pending, a_pending, swap, a_swap;

  int checks = 0;
  int failures = 0;
  int swaps = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (swap) swaps <= swaps + 1;

  kernel_scheduler dut (
    .clk_in(clk), .rst_in(rst_in), .next_in(next_in), .prev_in(prev_in),
    .frame_start_in(frame_in), .coeffs_out(coeffs), .shift_out(shift),
    .offset_out(offset), .kernel_id_out(kid), .pending_out(pending), .swap_out(swap)
  );

  kernel_scheduler #(.AUTO_FRAMES(3)) dut_auto (
    .clk_in(clk), .rst_in(rst_in), .next_in(a_next), .prev_in(a_prev),
    .frame_start_in(a_frame), .coeffs_out(a_coeffs), .shift_out(a_shift),
    .offset_out(a_offset), .kernel_id_out(a_kid), .pending_out(a_pending), .swap_out(a_swap)
  );

  function automatic logic [71:0] k9(input int c0, c1, c2, c3, c4, c5, c6, c7, c8);
    logic [71:0] v;
    v = {8'(c8), 8'(c7), 8'(c6), 8'(c5), 8'(c4), 8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    return v;
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 0 next, 1 prev, 2 frame on main DUT; 3 next, 4 frame on auto DUT
  task automatic pulse(input int which);
    case (which)
      0: next_in = 1'b1;
      1: prev_in = 1'b1;
      2: frame_in = 1'b1;
      3: a_next = 1'b1;
      default: a_frame = 1'b1;
    endcase
    @(negedge clk);
    next_in = 1'b0; prev_in = 1'b0; frame_in = 1'b0; a_next = 1'b0; a_frame = 1'b0;
  endtask

  task automatic frame_swap(input string tag, input int id, input logic [71:0] c,
                            input int sh, input int off);
    pulse(2);
    check({tag, "_swap_hi"}, 72'(swap), 72'd1);
    check({tag, "_id"}, 72'(kid), 72'(id));
    check({tag, "_coeffs"}, coeffs, c);
    check({tag, "_shift"}, 72'(shift), 72'(8'(sh)));
    check({tag, "_offset"}, 72'(offset), 72'(8'(off)));
    cyc(1);
    check({tag, "_swap_lo"}, 72'(swap), 72'd0);
  endtask

  logic [71:0] K_ID, K_GAUSS, K_SHARP, K_SOBY;

  initial begin
    K_ID    = k9(0, 0, 0, 0, 1, 0, 0, 0, 0);
    K_GAUSS = k9(1, 2, 1, 2, 4, 2, 1, 2, 1);
    K_SHARP = k9(0, -1, 0, -1, 5, -1, 0, -1, 0);
    K_SOBY  = k9(-1, -2, -1, 0, 0, 0, 1, 2, 1);

    cyc(2);
    check("rst_id", 72'(kid), 72'd7);
    check("rst_coeffs", coeffs, 72'd0);
    check("rst_shift", 72'(shift), 72'd0);
    check("rst_offset", 72'(offset), 72'd0);
    check("rst_swap", 72'(swap), 72'd0);
    check("rst_pending", 72'(pending), 72'd0);
    rst_in = 1'b0;
    cyc(1);
    check("post_rst_pending", 72'(pending), 72'd1);

    cyc(20);
    frame_swap("first", 0, K_ID, 0, 0);
    cyc(1);
    check("first_pending_lo", 72'(pending), 72'd0);
    check("first_swap_count", 72'(swaps), 72'd1);

    // prev from 0 wraps to the last kernel
    pulse(1);
    cyc(15);
    frame_swap("prev_wrap", 5, K_SOBY, 0, 0);
    check("prev_row0", 72'(coeffs[0]), 72'(k9(-1, -2, -1, 0, 0, 0, 0, 0, 0)) & 72'hFFFFFF);

    // next from the last kernel wraps to 0
    pulse(0);
    cyc(15);
    frame_swap("next_wrap", 0, K_ID, 0, 0);

    pulse(0);
    cyc(15);
    frame_swap("gauss", 1, K_GAUSS, 4, 0);

    pulse(1);
    cyc(15);
    frame_swap("back0", 0, K_ID, 0, 0);

    // Second press lands while idx 5 is loading; frames during LOAD must not swap.
    pulse(0);
    cyc(6);
    pulse(0);
    cyc(3);
    pulse(2);
    check("load_frame_noswap", 72'(swap), 72'd0);
    check("load_frame_id", 72'(kid), 72'd0);
    cyc(7);
    pulse(2);
    check("last_load_frame_noswap", 72'(swap), 72'd0);
    check("last_load_frame_id", 72'(kid), 72'd0);
    frame_swap("restart", 2, K_SHARP, 0, 16);
    check("restart_swap_count", 72'(swaps), 72'd6);

    // next then prev before the swap: abort back to the active kernel
    pulse(0);
    cyc(2);
    pulse(1);
    cyc(3);
    check("abort_pending", 72'(pending), 72'd0);
    pulse(2);
    check("abort_noswap", 72'(swap), 72'd0);
    check("abort_id", 72'(kid), 72'd2);
    check("abort_coeffs", coeffs, K_SHARP);

    // simultaneous presses are ignored
    next_in = 1'b1; prev_in = 1'b1;
    cyc(1);
    next_in = 1'b0; prev_in = 1'b0;
    cyc(2);
    check("both_pending", 72'(pending), 72'd0);
    cyc(13);
    pulse(2);
    check("both_id", 72'(kid), 72'd2);
    check("both_swap_count", 72'(swaps), 72'd6);

    // auto-cycle every third frame
    pulse(4); cyc(15);
    check("auto_f1", 72'(a_kid), 72'd0);
    pulse(4); cyc(15);
    pulse(4); cyc(15);
    check("auto_f3", 72'(a_kid), 72'd0);
    pulse(4); cyc(15);
    check("auto_f4", 72'(a_kid), 72'd1);
    pulse(4); cyc(15);
    pulse(4); cyc(15);
    check("auto_f6", 72'(a_kid), 72'd1);
    pulse(4); cyc(15);
    check("auto_f7", 72'(a_kid), 72'd2);
    pulse(4); cyc(2);
    pulse(3); cyc(15);
    pulse(4); cyc(15);
    check("auto_manual", 72'(a_kid), 72'd3);
    pulse(4); cyc(15);
    check("auto_cnt_cleared_id", 72'(a_kid), 72'd3);
    check("auto_cnt_cleared_pend", 72'(a_pending), 72'd0);
    pulse(4); cyc(15);
    pulse(4); cyc(2);
    check("auto_after_clear", 72'(a_kid), 72'd4);

    // reset in the middle of a load discards everything
    pulse(0);
    cyc(5);
    rst_in = 1'b1;
    #1;
    check("midrst_id", 72'(kid), 72'd7);
    check("midrst_coeffs", coeffs, 72'd0);
    check("midrst_offset", 72'(offset), 72'd0);
    check("midrst_pending", 72'(pending), 72'd0);
    @(negedge clk);
    rst_in = 1'b0;
    cyc(15);
    frame_swap("after_rst", 0, K_ID, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kernel_scheduler.md
# kernel_scheduler

Frame-synchronous kernel controller for the 3x3 convolution filter. It holds the six-kernel coefficient table and tracks the user's kernel selection (next/prev buttons, optional auto-cycle). It preloads the chosen kernel into a shadow bank one entry per cycle, then swaps it into the active outputs only on a frame-start pulse, so no frame is filtered with mixed coefficients. Its outputs feed the convolution datapath's coeffs/shift/offset inputs directly.

## Interface
- NUM_KERNELS, 6: number of table entries used; selection wraps at this value.
- DEFAULT_KERNEL, 0: selection after reset.
- AUTO_FRAMES, 0: if nonzero, selection advances by one every AUTO_FRAMES frame-start pulses. If 0, auto-cycle is off.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; asynchronous and active-high.
- next_in  input  1  single-cycle pulse (debounced upstream): select next kernel.
- prev_in  input  1  single-cycle pulse: select previous kernel.
- frame_start_in  input  1  single-cycle pulse at the first pixel of each frame.
- coeffs_out  output  signed [2:0][2:0][7:0]  active coefficients, [row][col].
- shift_out  output  [7:0]  active right-shift.
- offset_out  output  signed [7:0]  active offset.
- kernel_id_out  output  [2:0]  active kernel index; 7 = none loaded.
- pending_out  output  1  high while a change is queued or loading.
- swap_out  output  1  one-cycle pulse, high in the cycle the new kernel becomes active.

## Operation
- Table, row-major coeffs / shift / offset:
  - 0 identity: 0,0,0,0,1,0,0,0,0 / 0 / 0
  - 1 gaussian: 1,2,1,2,4,2,1,2,1 / 4 / 0
  - 2 sharpen: 0,-1,0,-1,5,-1,0,-1,0 / 0 / 16
  - 3 ridge: -1 everywhere, centre 8 / 0 / 16
  - 4 sobel-x: 1,0,-1,2,0,-2,1,0,-1 / 0 / 0
  - 5 sobel-y: -1,-2,-1,0,0,0,1,2,1 / 0 / 0
  - Any index >= 6 reads as identity.
- sel register:
  - next_in: sel = (sel+1) mod NUM_KERNELS.
  - prev_in: sel = sel-1, wrapping 0 -> NUM_KERNELS-1.
  - next_in and prev_in in the same cycle: ignored.
  - Auto-advance has the same effect as next_in. If it coincides with a manual press, the manual press wins.
  - Frame counter counts frame_start_in pulses. It clears to 0 on any manual press and on auto-advance.
- FSM states:
  - IDLE: sel == kernel_id_out. pending_out=0.
  - LOAD: load_id latched from sel on entry; idx counts 0..10. Each cycle writes shadow entry idx: 0..8 = coeff[idx/3][idx%3], 9 = shift, 10 = offset.
  - READY: shadow complete, waiting for frame_start_in.
- Transitions:
  - IDLE -> LOAD when sel != kernel_id_out.
  - LOAD -> READY after writing idx 10.
  - READY -> IDLE on frame_start_in: active regs <= shadow, kernel_id_out <= load_id, swap_out=1.
- Selection change during LOAD or READY:
  - If new sel == kernel_id_out, abort to IDLE. Active outputs are untouched.
  - Otherwise restart LOAD at idx 0 with the new load_id.
- frame_start_in during IDLE or LOAD causes no swap; the swap is deferred to the next frame.

## Timing
- Reset values (async):
  - coeffs_out = all 0, shift_out = 0, offset_out = 0.
  - kernel_id_out = 7, swap_out = 0.
  - sel = DEFAULT_KERNEL, frame counter = 0, state = IDLE.
  - pending_out goes high the cycle after reset releases, because sel != 7.
- Press at cycle T: sel updates at edge T+1. LOAD is entered at T+2. READY is reached 11 cycles after LOAD entry.
- Swap: outputs change on the edge that samples frame_start_in while in READY. swap_out is high during the following cycle only.
- All outputs are registered; no combinational path from inputs to outputs.
- pending_out = (state != IDLE) || (sel != kernel_id_out).
- Reset mid-LOAD: all state returns to reset values immediately; the partial shadow bank is discarded.

## Test plan
- Reset release, then frame_start_in 20 cycles later: kernel_id_out = 0, coeffs_out[1][1] = 1, all others 0, single swap_out pulse.
- From kernel 0, next_in, wait READY, frame_start_in: kernel_id_out = 1, shift_out = 4, coeffs = 1,2,1,2,4,2,1,2,1.
- prev_in from 0 with NUM_KERNELS = 6 -> sel 5 after the frame swap: row 0 = -1,-2,-1.
- next_in at LOAD idx 5, then frame_start_in as soon as READY: kernel_id_out = 2, offset_out = 16, no mixed coefficients. A frame_start_in during LOAD produces no swap.
- next_in then prev_in before the swap: FSM aborts to IDLE, no swap_out, pending_out = 0. Simultaneous next_in + prev_in: no change.
- AUTO_FRAMES = 3: kernel_id_out steps 0 -> 1 -> 2 every third frame. A manual press resets the count.
